mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the core's fetch port (pc/instr_in) and data port (daddr/data_out/mem_data).

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports of the core.
// Data wins over fetch until MAX_DSTREAK consecutive data grants have been made
// while fetch was waiting; one transaction is in flight at a time.
module mem_port_arbiter #(
  parameter int unsigned     AW          = 32,
  parameter int unsigned     DW          = 32,
  parameter int unsigned     MAX_DSTREAK = 4,
  parameter logic [DW-1:0]   NOP_INSTR   = DW'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  // core stall
  output logic          stall
);

  localparam int unsigned     SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] dstreak;
  logic          d_elig;
  logic          f_elig;
  logic          grant_d;
  logic          grant_f;

  // Arbitration: a requester is not eligible during its own valid (release) cycle.
  always_comb begin
    d_elig  = d_req & ~d_valid;
    f_elig  = if_req & ~if_valid;
    grant_d = d_elig & (~f_elig | (dstreak < STREAK_MAX));
    grant_f = f_elig & ~grant_d;
  end

  // Stall depends only on request inputs and the registered valids.
  always_comb begin
    stall = (if_req & ~if_valid) | (d_req & ~d_valid);
  end

  // Transaction FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dstreak   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= NOP_INSTR;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req) begin
              dstreak <= '0;
            end else if (dstreak != STREAK_MAX) begin
              dstreak <= dstreak + SW'(1);
            end
          end else if (grant_f) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            dstreak  <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_valid <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers the
// memory side, expected read data is queued when each request is driven and
// checked when the matching valid pulse appears.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack   = 1'b0;
  logic          stall;

  mem_port_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .MAX_DSTREAK (4),
    .NOP_INSTR   (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] last_load;
  int          ack_delay;
  logic        prev_if;
  logic        prev_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: fixed instruction words at 0x100/0x200, RAM elsewhere; acks after ack_delay wait cycles.
  logic [31:0] ram [0:255] = '{default: 32'h0};
  int          wait_cnt = 0;
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = (mem_addr == 32'h100) ? 32'h0050_0093 :
                    (mem_addr == 32'h200) ? 32'h00A0_0113 : ram[mem_addr[9:2]];
        if (mem_we) ram[mem_addr[9:2]] = mem_wdata;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Grant log: one entry per rising edge of mem_req.
  logic [31:0] g_addr[$];
  logic [31:0] g_we[$];
  logic [31:0] g_wdata[$];
  int          n_grant = 0;
  logic        req_q   = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_req && !req_q) begin
      g_addr.push_back(mem_addr);
      g_we.push_back(32'(mem_we));
      g_wdata.push_back(mem_wdata);
      n_grant = n_grant + 1;
    end
    req_q = mem_req;
  end

  task automatic check_grant(input string tag, input int idx, input logic [31:0] addr,
                             input logic [31:0] we);
    check_eq({tag, "_present"}, 32'(g_addr.size() > idx), 1);
    if (g_addr.size() > idx) begin
      check_eq({tag, "_addr"}, g_addr[idx], addr);
      check_eq({tag, "_we"}, g_we[idx], we);
    end
  endtask

  // Waits for the selected valid pulse; lat counts negedges from request drive.
  task automatic wait_valid(input bit is_d, input bit chk_stall, output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (is_d ? d_valid : if_valid) begin
        if (chk_stall) check_eq("stall_release", 32'(stall), 0);
        return;
      end
      if (chk_stall) check_eq("stall_wait", 32'(stall), 1);
    end
    check_eq("valid_timeout", 32'(is_d ? d_valid : if_valid), 1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input int exp_lat);
    int lat;
    int g0;
    @(negedge clk);
    if_addr = addr;
    if_req  = 1'b1;
    exp_if_q.push_back(exp);
    g0 = n_grant;
    wait_valid(1'b0, 1'b1, lat);
    if_req = 1'b0;
    check_eq("if_latency", 32'(lat), 32'(exp_lat));
    check_grant("fetch_grant", g0, addr, 0);
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input int exp_lat);
    int lat;
    int g0;
    @(negedge clk);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    exp_d_q.push_back(exp);
    g0 = n_grant;
    wait_valid(1'b1, 1'b1, lat);
    d_req = 1'b0;
    check_eq("d_latency", 32'(lat), 32'(exp_lat));
    check_grant("data_grant", g0, addr, 32'(we));
    if (we && g_wdata.size() > g0) check_eq("data_grant_wdata", g_wdata[g0], wdata);
  endtask

  initial begin
    int g0;
    int lat;
    logic [31:0] exp_seq [0:9];

    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    ack_delay = 0;
    last_load = '0;
    prev_if   = 1'b0;
    prev_d    = 1'b0;

    // Scoreboard consumer: pops one expectation per valid pulse.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (if_valid) begin
            check_eq("if_pulse_len", 32'(prev_if), 0);
            if (exp_if_q.size() == 0) check_eq("if_unexpected", 32'(if_valid), 0);
            else check_eq("if_rdata", if_rdata, exp_if_q.pop_front());
          end
          if (d_valid) begin
            check_eq("d_pulse_len", 32'(prev_d), 0);
            if (exp_d_q.size() == 0) check_eq("d_unexpected", 32'(d_valid), 0);
            else check_eq("d_rdata", d_rdata, exp_d_q.pop_front());
          end
        end
        prev_if = if_valid;
        prev_d  = d_valid;
      end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_if_rdata", if_rdata, 32'h0000_0013);
    check_eq("rst_if_valid", 32'(if_valid), 0);
    check_eq("rst_d_valid", 32'(d_valid), 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Fetch only, immediate ack
    do_fetch(32'h100, 32'h0050_0093, 2);

    // Reset in the middle of a store that is never acked
    @(negedge clk);
    ack_delay = 100;
    d_we      = 1'b1;
    d_addr    = 32'h80;
    d_wdata   = 32'h55;
    d_req     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midtx_mem_req", 32'(mem_req), 1);
    check_eq("midtx_mem_we", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    check_eq("async_mem_req", 32'(mem_req), 0);
    check_eq("async_mem_we", 32'(mem_we), 0);
    check_eq("async_if_rdata", if_rdata, 32'h0000_0013);
    check_eq("async_mem_addr", mem_addr, 0);
    d_req     = 1'b0;
    d_we      = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_mem_req", 32'(mem_req), 0);
      check_eq("post_rst_d_valid", 32'(d_valid), 0);
    end
    // Arbiter back in IDLE: next fetch has minimum latency
    do_fetch(32'h200, 32'h00A0_0113, 2);

    // Store / load / store with 3 ack wait cycles
    ack_delay = 3;
    do_data(1'b1, 32'h40, 32'hDEAD_BEEF, last_load, 5);
    last_load = 32'hDEAD_BEEF;
    do_data(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 5);
    do_data(1'b1, 32'h44, 32'hCAFE_F00D, last_load, 5);
    ack_delay = 0;

    // Starvation bound: fetch drops only in data release cycles
    exp_seq = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h200,
                32'h40, 32'h40, 32'h40, 32'h40, 32'h200};
    for (int k = 0; k < 8; k++) exp_d_q.push_back(32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) exp_if_q.push_back(32'h00A0_0113);
    g0 = n_grant;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    if_addr = 32'h200;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_grant - g0 >= 10) begin
        d_req = 1'b0;
        if (if_valid) begin
          if_req = 1'b0;
          break;
        end
      end else begin
        d_req  = 1'b1;
        if_req = !d_valid;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check_eq("starve_grant_count", 32'(n_grant - g0), 10);
    for (int k = 0; k < 10; k++) begin
      if (g_addr.size() > g0 + k) check_eq("starve_order", g_addr[g0 + k], exp_seq[k]);
    end
    repeat (2) @(negedge clk);
    check_eq("starve_idle", 32'(mem_req), 0);

    // Simultaneous requests from IDLE with a clear streak: data first
    @(negedge clk);
    g0      = n_grant;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    if_addr = 32'h100;
    exp_d_q.push_back(32'hDEAD_BEEF);
    exp_if_q.push_back(32'h0050_0093);
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_valid(1'b1, 1'b0, lat);
    d_req = 1'b0;
    check_eq("simul_d_latency", 32'(lat), 2);
    @(negedge clk);
    check_eq("simul_fetch_next", 32'(mem_req), 1);
    check_eq("simul_fetch_addr", mem_addr, 32'h100);
    wait_valid(1'b0, 1'b0, lat);
    if_req = 1'b0;
    check_grant("simul_first", g0, 32'h40, 0);
    check_grant("simul_second", g0 + 1, 32'h100, 0);

    // Release cycle: d_req still high during d_valid must not regrant
    @(negedge clk);
    g0     = n_grant;
    d_we   = 1'b0;
    d_addr = 32'h44;
    exp_d_q.push_back(32'hCAFE_F00D);
    d_req  = 1'b1;
    wait_valid(1'b1, 1'b1, lat);
    @(negedge clk);
    check_eq("release_no_grant", 32'(mem_req), 0);
    check_eq("release_grant_count", 32'(n_grant - g0), 1);
    d_req = 1'b0;
    @(negedge clk);
    check_eq("release_still_idle", 32'(mem_req), 0);

    // Drain
    repeat (3) @(negedge clk);
    check_eq("if_q_drained", 32'(exp_if_q.size()), 0);
    check_eq("d_q_drained", 32'(exp_d_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
